// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared state encoding and defaults for the UART packet receive path
package uart_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_LEN     = 3'd1,
      ST_PAYLOAD = 3'd2,
      ST_CHK     = 3'd3,
      ST_HOLD    = 3'd4
   } pkt_state_t;

   localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

   // gap budget: two full character times (start + 8 data + stop) of oversampling ticks
   localparam int TICKS_PER_BIT         = 16;
   localparam int BITS_PER_CHAR         = 10;
   localparam int GAP_CHARS             = 2;
   localparam int DEFAULT_TIMEOUT_TICKS = GAP_CHARS * BITS_PER_CHAR * TICKS_PER_BIT;

   function automatic logic [7:0] sum8(input logic [7:0] a, input logic [7:0] b);
      return a + b;
   endfunction

endpackage

// File: rtl/uart_pkt_buf.sv
// rtl/uart_pkt_buf.sv - payload byte buffer, synchronous write and combinational read
module uart_pkt_buf #(
   parameter int DEPTH = 16,
   parameter int AW    = 4
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] wr_addr,
   input  logic [7:0]    wr_data,
   input  logic [AW-1:0] rd_addr,
   output logic [7:0]    rd_data
);

   logic [7:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[wr_addr] <= wr_data;
      end
   end

   assign rd_data = mem[rd_addr];

endmodule

// File: rtl/uart_rx_pkt_ctrl.sv
// rtl/uart_rx_pkt_ctrl.sv - framed packet capture behind the UART byte receiver
module uart_rx_pkt_ctrl
   import uart_pkg::*;
#(
   parameter int         MAX_LEN       = 16,
   parameter logic [7:0] SYNC_BYTE     = DEFAULT_SYNC_BYTE,
   parameter int         TIMEOUT_TICKS = DEFAULT_TIMEOUT_TICKS,
   localparam int        AW            = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1,
   localparam int        TW            = $clog2(TIMEOUT_TICKS)
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          s_tick,
   input  logic          rx_done_tick,
   input  logic [7:0]    rx_data,
   output logic          pkt_valid,
   input  logic          pkt_ready,
   output logic [7:0]    pkt_len,
   input  logic [AW-1:0] rd_addr,
   output logic [7:0]    rd_data,
   output logic          err_len,
   output logic          err_chk,
   output logic          err_timeout,
   output logic          overrun
);

   pkt_state_t    state, state_nxt;
   logic [7:0]    sum, sum_nxt;
   logic [AW-1:0] idx, idx_nxt;
   logic [TW-1:0] cnt, cnt_nxt;
   logic [7:0]    len_q, len_nxt;
   logic          err_len_q, err_len_nxt;
   logic          err_chk_q, err_chk_nxt;
   logic          err_to_q, err_to_nxt;
   logic          ovr_q, ovr_nxt;
   logic          buf_we;
   logic          in_frame;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= ST_IDLE;
         sum       <= '0;
         idx       <= '0;
         cnt       <= '0;
         len_q     <= '0;
         err_len_q <= 1'b0;
         err_chk_q <= 1'b0;
         err_to_q  <= 1'b0;
         ovr_q     <= 1'b0;
      end else begin
         state     <= state_nxt;
         sum       <= sum_nxt;
         idx       <= idx_nxt;
         cnt       <= cnt_nxt;
         len_q     <= len_nxt;
         err_len_q <= err_len_nxt;
         err_chk_q <= err_chk_nxt;
         err_to_q  <= err_to_nxt;
         ovr_q     <= ovr_nxt;
      end
   end

   always_comb begin
      state_nxt   = state;
      sum_nxt     = sum;
      idx_nxt     = idx;
      cnt_nxt     = cnt;
      len_nxt     = len_q;
      err_len_nxt = 1'b0;
      err_chk_nxt = 1'b0;
      err_to_nxt  = 1'b0;
      ovr_nxt     = 1'b0;
      buf_we      = 1'b0;
      in_frame    = (state == ST_LEN) || (state == ST_PAYLOAD) || (state == ST_CHK);

      case (state)
         ST_IDLE: begin
            cnt_nxt = '0;
            if (rx_done_tick && (rx_data == SYNC_BYTE)) begin
               state_nxt = ST_LEN;
            end
         end
         ST_LEN: begin
            if (rx_done_tick) begin
               sum_nxt = rx_data;
               if ((rx_data == 8'd0) || (rx_data > 8'(MAX_LEN))) begin
                  err_len_nxt = 1'b1;
                  state_nxt   = ST_IDLE;
               end else begin
                  len_nxt   = rx_data;
                  idx_nxt   = '0;
                  state_nxt = ST_PAYLOAD;
               end
            end
         end
         ST_PAYLOAD: begin
            if (rx_done_tick) begin
               buf_we  = 1'b1;
               sum_nxt = sum8(sum, rx_data);
               // index stops on the last slot so it never leaves the buffer range
               if (8'(idx) == (len_q - 8'd1)) begin
                  state_nxt = ST_CHK;
               end else begin
                  idx_nxt = idx + AW'(1);
               end
            end
         end
         ST_CHK: begin
            if (rx_done_tick) begin
               if (rx_data == sum) begin
                  state_nxt = ST_HOLD;
               end else begin
                  err_chk_nxt = 1'b1;
                  state_nxt   = ST_IDLE;
               end
            end
         end
         ST_HOLD: begin
            cnt_nxt = '0;
            if (rx_done_tick) begin
               ovr_nxt = 1'b1;
            end
            if (pkt_ready) begin
               state_nxt = ST_IDLE;
            end
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase

      // a byte landing on the terminal tick wins over the timeout
      if (in_frame) begin
         if (rx_done_tick) begin
            cnt_nxt = '0;
         end else if (s_tick) begin
            if (cnt == TW'(TIMEOUT_TICKS - 1)) begin
               err_to_nxt = 1'b1;
               cnt_nxt    = '0;
               state_nxt  = ST_IDLE;
            end else begin
               cnt_nxt = cnt + TW'(1);
            end
         end
      end
   end

   uart_pkt_buf #(
      .DEPTH (MAX_LEN),
      .AW    (AW)
   ) u_buf (
      .clk     (clk),
      .we      (buf_we),
      .wr_addr (idx),
      .wr_data (rx_data),
      .rd_addr (rd_addr),
      .rd_data (rd_data)
   );

   assign pkt_valid   = (state == ST_HOLD);
   assign pkt_len     = len_q;
   assign err_len     = err_len_q;
   assign err_chk     = err_chk_q;
   assign err_timeout = err_to_q;
   assign overrun     = ovr_q;

endmodule

// File: tb/tb_uart_rx_pkt_ctrl.sv
// tb/tb_uart_rx_pkt_ctrl.sv - scoreboard bench for uart_rx_pkt_ctrl
module tb_uart_rx_pkt_ctrl;

   localparam int EV_PKT = 1;
   localparam int EV_LEN = 2;
   localparam int EV_CHK = 3;
   localparam int EV_TO  = 4;
   localparam int EV_OVR = 5;

   typedef logic [7:0] byte_q_t [$];

   logic       clk          = 1'b0;
   logic       reset_n      = 1'b1;
   logic       s_tick       = 1'b0;
   logic       rx_done_tick = 1'b0;
   logic [7:0] rx_data      = 8'h00;
   logic       pkt_ready    = 1'b0;
   logic [3:0] rd_addr      = 4'h0;
   logic       pkt_valid;
   logic [7:0] pkt_len;
   logic [7:0] rd_data;
   logic       err_len;
   logic       err_chk;
   logic       err_timeout;
   logic       overrun;

   int         n_assert = 0;
   int         n_fail   = 0;
   int         ev_exp_q[$];
   int         ev_obs_q[$];
   logic [7:0] pkt_exp_q[$];
   logic       pv_d = 1'b0;

   always #5 clk = ~clk;

   uart_rx_pkt_ctrl #(
      .MAX_LEN       (16),
      .SYNC_BYTE     (8'hA5),
      .TIMEOUT_TICKS (320)
   ) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .s_tick       (s_tick),
      .rx_done_tick (rx_done_tick),
      .rx_data      (rx_data),
      .pkt_valid    (pkt_valid),
      .pkt_ready    (pkt_ready),
      .pkt_len      (pkt_len),
      .rd_addr      (rd_addr),
      .rd_data      (rd_data),
      .err_len      (err_len),
      .err_chk      (err_chk),
      .err_timeout  (err_timeout),
      .overrun      (overrun)
   );

   // observed-event monitor, sampled on the inactive edge
   always @(negedge clk) begin
      if (!reset_n) begin
         pv_d <= 1'b0;
      end else begin
         if (pkt_valid && !pv_d) ev_obs_q.push_back(EV_PKT);
         if (err_len)            ev_obs_q.push_back(EV_LEN);
         if (err_chk)            ev_obs_q.push_back(EV_CHK);
         if (err_timeout)        ev_obs_q.push_back(EV_TO);
         if (overrun)            ev_obs_q.push_back(EV_OVR);
         pv_d <= pkt_valid;
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send_byte(input logic [7:0] b, input logic with_tick);
      rx_data      = b;
      rx_done_tick = 1'b1;
      s_tick       = with_tick;
      cyc(1);
      rx_done_tick = 1'b0;
      s_tick       = 1'b0;
   endtask

   task automatic send_frame(input byte_q_t f);
      foreach (f[i]) begin
         send_byte(f[i], 1'b0);
         cyc(1);
      end
   endtask

   task automatic ticks(input int n);
      repeat (n) begin
         s_tick = 1'b1;
         cyc(1);
         s_tick = 1'b0;
         cyc(1);
      end
   endtask

   task automatic expect_pkt(input byte_q_t payload);
      ev_exp_q.push_back(EV_PKT);
      pkt_exp_q.push_back(8'(payload.size()));
      foreach (payload[i]) pkt_exp_q.push_back(payload[i]);
   endtask

   task automatic sb_drain(input string tag);
      cyc(3);
      for (int i = 0; i < 50 && ev_obs_q.size() < ev_exp_q.size(); i++) cyc(1);
      check({tag, " event count"}, ev_obs_q.size(), ev_exp_q.size());
      while (ev_obs_q.size() > 0 && ev_exp_q.size() > 0) begin
         check({tag, " event"}, ev_obs_q.pop_front(), ev_exp_q.pop_front());
      end
      ev_obs_q.delete();
      ev_exp_q.delete();
   endtask

   task automatic check_pkt(input string tag);
      logic [7:0] len;
      check({tag, " valid"}, pkt_valid, 1);
      len = pkt_exp_q.pop_front();
      check({tag, " len"}, pkt_len, len);
      for (int i = 0; i < int'(len); i++) begin
         rd_addr = 4'(i);
         #1;
         check($sformatf("%s byte%0d", tag, i), rd_data, pkt_exp_q.pop_front());
      end
      cyc(1);
   endtask

   task automatic accept(input string tag);
      pkt_ready = 1'b1;
      cyc(1);
      pkt_ready = 1'b0;
      check({tag, " released"}, pkt_valid, 0);
   endtask

   task automatic check_zero(input string tag);
      check({tag, " pkt_valid"}, pkt_valid, 0);
      check({tag, " pkt_len"}, pkt_len, 0);
      check({tag, " err_len"}, err_len, 0);
      check({tag, " err_chk"}, err_chk, 0);
      check({tag, " err_timeout"}, err_timeout, 0);
      check({tag, " overrun"}, overrun, 0);
   endtask

   initial begin
      byte_q_t    frm;
      byte_q_t    pl;
      logic [7:0] chk;

      reset_n = 1'b0;
      cyc(1);
      check_zero("reset");
      cyc(1);
      reset_n = 1'b1;
      cyc(2);

      // basic packet and handshake
      frm = {8'hA5, 8'h02, 8'h10, 8'h20, 8'h32};
      pl  = {8'h10, 8'h20};
      expect_pkt(pl);
      send_frame(frm);
      sb_drain("good");
      check_pkt("good");
      accept("good");

      // checksum error, then recovery
      frm = {8'hA5, 8'h02, 8'h10, 8'h20, 8'h33};
      ev_exp_q.push_back(EV_CHK);
      send_frame(frm);
      sb_drain("badchk");
      check("badchk no valid", pkt_valid, 0);
      frm = {8'hA5, 8'h01, 8'h7F, 8'h80};
      pl  = {8'h7F};
      expect_pkt(pl);
      send_frame(frm);
      sb_drain("after chk");
      check_pkt("after chk");
      accept("after chk");

      // length errors and junk before sync
      frm = {8'hA5, 8'h00};
      ev_exp_q.push_back(EV_LEN);
      send_frame(frm);
      sb_drain("len0");
      frm = {8'hA5, 8'h11};
      ev_exp_q.push_back(EV_LEN);
      send_frame(frm);
      sb_drain("len17");
      frm = {8'h00, 8'hFF, 8'hA5, 8'h01, 8'h05, 8'h06};
      pl  = {8'h05};
      expect_pkt(pl);
      send_frame(frm);
      sb_drain("junk");
      check_pkt("junk");
      accept("junk");

      // maximum length, payload includes the sync value
      pl  = {};
      chk = 8'd16;
      for (int i = 0; i < 16; i++) begin
         pl.push_back(8'(8'hA5 + i * 7));
         chk = chk + 8'(8'hA5 + i * 7);
      end
      frm = {8'hA5, 8'h10};
      foreach (pl[i]) frm.push_back(pl[i]);
      frm.push_back(chk);
      expect_pkt(pl);
      send_frame(frm);
      sb_drain("maxlen");
      check_pkt("maxlen");
      accept("maxlen");

      // gap timeout on exactly the 320th tick
      frm = {8'hA5, 8'h03, 8'h01};
      send_frame(frm);
      ticks(319);
      sb_drain("to 319");
      ev_exp_q.push_back(EV_TO);
      ticks(1);
      sb_drain("to 320");

      // byte coinciding with tick 320 clears the counter
      frm = {8'hA5, 8'h03, 8'h01};
      send_frame(frm);
      ticks(319);
      send_byte(8'h02, 1'b1);
      cyc(1);
      ticks(319);
      sb_drain("byte wins");
      frm = {8'h03, 8'h09};
      pl  = {8'h01, 8'h02, 8'h03};
      expect_pkt(pl);
      send_frame(frm);
      sb_drain("byte wins pkt");
      check_pkt("byte wins pkt");
      accept("byte wins pkt");

      // overrun while held, and on the handshake cycle
      frm = {8'hA5, 8'h02, 8'h10, 8'h20, 8'h32};
      pl  = {8'h10, 8'h20};
      expect_pkt(pl);
      send_frame(frm);
      sb_drain("hold");
      check_pkt("hold");
      ev_exp_q.push_back(EV_OVR);
      send_byte(8'h55, 1'b0);
      cyc(1);
      sb_drain("ovr held");
      pkt_exp_q.push_back(8'h02);
      pkt_exp_q.push_back(8'h10);
      pkt_exp_q.push_back(8'h20);
      check_pkt("ovr held");
      ev_exp_q.push_back(EV_OVR);
      pkt_ready = 1'b1;
      send_byte(8'hA5, 1'b0);
      pkt_ready = 1'b0;
      check("ovr hs released", pkt_valid, 0);
      frm = {8'h01, 8'h7F, 8'h80};
      send_frame(frm);
      sb_drain("ovr hs");

      // asynchronous reset mid-payload and in hold
      frm = {8'hA5, 8'h03, 8'h01};
      send_frame(frm);
      reset_n = 1'b0;
      #1;
      check_zero("rst payload");
      cyc(1);
      reset_n = 1'b1;
      cyc(1);
      frm = {8'hA5, 8'h01, 8'hAA, 8'hAB};
      pl  = {8'hAA};
      expect_pkt(pl);
      send_frame(frm);
      sb_drain("rst next");
      check_pkt("rst next");
      reset_n = 1'b0;
      #1;
      check_zero("rst hold");
      cyc(1);
      reset_n = 1'b1;
      cyc(1);
      expect_pkt(pl);
      send_frame(frm);
      sb_drain("rst again");
      check_pkt("rst again");
      accept("rst again");

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
